// File: rtl/id_stage_pipe.sv
// Decode stage: register file, control decode, early branch/jump resolution and hazard detection, registered into ID/EX.
// Optional macro ID_BNE_EN adds bne (opcode 000101) as an inverted-compare beq.
module id_stage_pipe #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_valid,
  input  logic [DATA_W-1:0]     if_pc,
  input  logic [31:0]           if_instr,
  input  logic                  wb_regwrite,
  input  logic [REG_ADDR_W-1:0] wb_wn,
  input  logic [DATA_W-1:0]     wb_wd,
  input  logic                  mem_regwrite,
  input  logic                  mem_memread,
  input  logic [REG_ADDR_W-1:0] mem_wn,
  input  logic [DATA_W-1:0]     mem_alu,
  output logic                  stall,
  output logic                  flush_if,
  output logic [1:0]            pc_sel,
  output logic [DATA_W-1:0]     pc_target,
  output logic                  ex_valid,
  output logic                  ex_regwrite,
  output logic                  ex_memread,
  output logic                  ex_memwrite,
  output logic                  ex_memtoreg,
  output logic                  ex_alusrc,
  output logic                  ex_regdst,
  output logic [1:0]            ex_aluop,
  output logic [DATA_W-1:0]     ex_rd1,
  output logic [DATA_W-1:0]     ex_rd2,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_rd
);
  localparam int NREG = 2 ** REG_ADDR_W;

  typedef struct packed {
    logic       regwrite, memread, memwrite, memtoreg, alusrc, regdst;
    logic [1:0] aluop;
    logic       br, bne, jmp, uses_rt;
  } ctrl_t;

  logic [DATA_W-1:0]     rf [NREG];
  logic [5:0]            opcode;
  logic [REG_ADDR_W-1:0] rs, rt, rd, ex_dst;
  logic [DATA_W-1:0]     rd1, rd2, op_a, op_b, imm, br_tgt, jmp_tgt;
  logic [31:0]           jmp_raw;
  logic                  load_use, br_dep, br_load, taken, bubble;
  ctrl_t                 c;

  assign opcode = if_instr[31:26];
  assign rs     = REG_ADDR_W'(if_instr[25:21]);
  assign rt     = REG_ADDR_W'(if_instr[20:16]);
  assign rd     = REG_ADDR_W'(if_instr[15:11]);
  assign imm    = {{(DATA_W-16){if_instr[15]}}, if_instr[15:0]};

  always_comb begin
    c = '0;
    case (opcode)
      6'b000000: begin c.regdst = 1'b1; c.regwrite = 1'b1; c.aluop = 2'b10; c.uses_rt = 1'b1; end
      6'b100011: begin c.alusrc = 1'b1; c.memread = 1'b1; c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      6'b101011: begin c.alusrc = 1'b1; c.memwrite = 1'b1; c.uses_rt = 1'b1; end
      6'b000100: begin c.aluop = 2'b01; c.br = 1'b1; c.uses_rt = 1'b1; end
`ifdef ID_BNE_EN
      6'b000101: begin c.aluop = 2'b01; c.br = 1'b1; c.bne = 1'b1; c.uses_rt = 1'b1; end
`endif
      6'b000010: c.jmp = 1'b1;
      default:   c = '0;
    endcase
  end

  // Register file; WB write bypasses into same-cycle reads, r0 is hardwired zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_regwrite && wb_wn != '0) begin
      rf[wb_wn] <= wb_wd;
    end
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (rs != '0) rd1 = (wb_regwrite && wb_wn == rs) ? wb_wd : rf[rs];
    if (rt != '0) rd2 = (wb_regwrite && wb_wn == rt) ? wb_wd : rf[rt];
  end

  // Only ALU results are forwardable from MEM; a MEM load stalls instead.
  assign op_a = (mem_regwrite && !mem_memread && mem_wn != '0 && mem_wn == rs) ? mem_alu : rd1;
  assign op_b = (mem_regwrite && !mem_memread && mem_wn != '0 && mem_wn == rt) ? mem_alu : rd2;

  assign ex_dst   = ex_regdst ? ex_rd : ex_rt;
  assign load_use = ex_valid && ex_memread && ex_rt != '0 &&
                    (ex_rt == rs || (c.uses_rt && ex_rt == rt));
  assign br_dep   = c.br && ex_valid && ex_regwrite && (ex_dst == rs || ex_dst == rt);
  assign br_load  = c.br && mem_memread && mem_regwrite && mem_wn != '0 &&
                    (mem_wn == rs || mem_wn == rt);
  assign stall    = if_valid && (load_use || br_dep || br_load);

  assign taken    = c.br && ((op_a == op_b) ^ c.bne);
  assign br_tgt   = if_pc + (imm << 2);
  assign jmp_raw  = {if_pc[31:28], if_instr[25:0], 2'b00};
  assign jmp_tgt  = DATA_W'(jmp_raw);

  always_comb begin
    pc_sel = 2'd0;
    if (if_valid && !stall) begin
      if (taken)      pc_sel = 2'd1;
      else if (c.jmp) pc_sel = 2'd2;
    end
  end

  assign pc_target = c.jmp ? jmp_tgt : br_tgt;
  assign flush_if  = (pc_sel != 2'd0);
  assign bubble    = !if_valid || stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst || bubble) begin
      ex_valid    <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_alusrc   <= 1'b0;
      ex_regdst   <= 1'b0;
      ex_aluop    <= '0;
      ex_rd1      <= '0;
      ex_rd2      <= '0;
      ex_imm      <= '0;
      ex_rt       <= '0;
      ex_rd       <= '0;
    end else begin
      ex_valid    <= 1'b1;
      ex_regwrite <= c.regwrite;
      ex_memread  <= c.memread;
      ex_memwrite <= c.memwrite;
      ex_memtoreg <= c.memtoreg;
      ex_alusrc   <= c.alusrc;
      ex_regdst   <= c.regdst;
      ex_aluop    <= c.aluop;
      ex_rd1      <= rd1;
      ex_rd2      <= rd2;
      ex_imm      <= imm;
      ex_rt       <= rt;
      ex_rd       <= rd;
    end
  end
endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: expected ID/EX contents queued at issue, popped one clock later.
module tb_id_stage_pipe;
  logic        clk = 1'b0, rst = 1'b1;
  logic        if_valid = 1'b0;
  logic [31:0] if_pc = '0, if_instr = '0;
  logic        wb_regwrite = 1'b0, mem_regwrite = 1'b0, mem_memread = 1'b0;
  logic [4:0]  wb_wn = '0, mem_wn = '0;
  logic [31:0] wb_wd = '0, mem_alu = '0;
  logic        stall, flush_if;
  logic [1:0]  pc_sel;
  logic [31:0] pc_target;
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_regdst;
  logic [1:0]  ex_aluop;
  logic [31:0] ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rt, ex_rd;

  id_stage_pipe #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .wb_regwrite(wb_regwrite), .wb_wn(wb_wn), .wb_wd(wb_wd),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_wn(mem_wn), .mem_alu(mem_alu),
    .stall(stall), .flush_if(flush_if), .pc_sel(pc_sel), .pc_target(pc_target),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg), .ex_alusrc(ex_alusrc),
    .ex_regdst(ex_regdst), .ex_aluop(ex_aluop), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_imm(ex_imm), .ex_rt(ex_rt), .ex_rd(ex_rd)
  );

  always #5 clk = ~clk;

  // ctl = {valid, regwrite, memread, memwrite, memtoreg, alusrc, regdst, aluop}
  typedef struct packed {
    logic [8:0]  ctl;
    logic [31:0] rd1, rd2, imm;
    logic [9:0]  rtrd;
  } ex_t;

  localparam logic [8:0] C_R   = 9'b1_1_0_0_0_0_1_10;
  localparam logic [8:0] C_LW  = 9'b1_1_1_0_1_1_0_00;
  localparam logic [8:0] C_BR  = 9'b1_0_0_0_0_0_0_01;
  localparam logic [8:0] C_NOP = 9'b1_0_0_0_0_0_0_00;
  localparam ex_t BUBBLE = '0;

  int  n_chk = 0, n_err = 0;
  ex_t sb[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    return {6'b0, s, t, d, 5'b0, 6'h20};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                                        input logic [15:0] i);
    return {op, s, t, i};
  endfunction

  function automatic ex_t mk(input logic [8:0] ctl, input logic [31:0] ins,
                             input logic [31:0] a, input logic [31:0] b);
    ex_t e;
    e.ctl  = ctl;
    e.rd1  = a;
    e.rd2  = b;
    e.imm  = {{16{ins[15]}}, ins[15:0]};
    e.rtrd = {ins[20:16], ins[15:11]};
    return e;
  endfunction

  task automatic check_ex();
    ex_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    chk("ex_ctl", {ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc,
                   ex_regdst, ex_aluop}, e.ctl);
    chk("ex_rd1", ex_rd1, e.rd1);
    chk("ex_rd2", ex_rd2, e.rd2);
    chk("ex_imm", ex_imm, e.imm);
    chk("ex_rtrd", {ex_rt, ex_rd}, e.rtrd);
  endtask

  // One ID cycle: drive, check combinational outputs, queue expected ID/EX, clock, compare.
  task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic vld,
                      input logic exp_stall, input logic [1:0] exp_sel, input logic [31:0] exp_tgt,
                      input ex_t e);
    if_instr = ins;
    if_pc    = pc;
    if_valid = vld;
    #1;
    chk("stall", stall, exp_stall);
    chk("pc_sel", pc_sel, exp_sel);
    chk("flush_if", flush_if, exp_sel != 2'd0);
    if (exp_sel != 2'd0) chk("pc_target", pc_target, exp_tgt);
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_ex();
    wb_regwrite  = 1'b0;
    mem_regwrite = 1'b0;
    mem_memread  = 1'b0;
  endtask

  logic [31:0] ins;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl", {ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_aluop}, 0);
    chk("rst_stall", {stall, flush_if, pc_sel}, 0);
    rst = 1'b0;

    // WB write-through bypass, then r0 write ignored
    wb_regwrite = 1'b1; wb_wn = 5'd3; wb_wd = 32'h1234;
    ins = rtype(5'd3, 5'd3, 5'd1);
    step(ins, 32'h0, 1'b1, 1'b0, 2'd0, 32'h0, mk(C_R, ins, 32'h1234, 32'h1234));
    wb_regwrite = 1'b1; wb_wn = 5'd0; wb_wd = 32'hdead;
    ins = rtype(5'd0, 5'd3, 5'd2);
    step(ins, 32'h0, 1'b1, 1'b0, 2'd0, 32'h0, mk(C_R, ins, 32'h0, 32'h1234));
    ins = rtype(5'd0, 5'd0, 5'd9);
    step(ins, 32'h0, 1'b1, 1'b0, 2'd0, 32'h0, mk(C_R, ins, 32'h0, 32'h0));

    // load-use: one stall cycle with bubble, then the add issues
    ins = itype(6'b100011, 5'd3, 5'd2, 16'h0);
    step(ins, 32'h0, 1'b1, 1'b0, 2'd0, 32'h0, mk(C_LW, ins, 32'h1234, 32'h0));
    ins = rtype(5'd2, 5'd2, 5'd4);
    step(ins, 32'h0, 1'b1, 1'b1, 2'd0, 32'h0, BUBBLE);
    step(ins, 32'h0, 1'b1, 1'b0, 2'd0, 32'h0, mk(C_R, ins, 32'h0, 32'h0));

    // beq taken / not taken
    ins = itype(6'b000100, 5'd1, 5'd1, 16'd4);
    step(ins, 32'h100, 1'b1, 1'b0, 2'd1, 32'h110, mk(C_BR, ins, 32'h0, 32'h0));
    ins = itype(6'b000100, 5'd1, 5'd3, 16'd4);
    step(ins, 32'h100, 1'b1, 1'b0, 2'd0, 32'h0, mk(C_BR, ins, 32'h0, 32'h1234));

    // MEM forwarding into compare (r7 = 7 written via WB bypass the same cycle)
    wb_regwrite = 1'b1; wb_wn = 5'd7; wb_wd = 32'd7;
    mem_regwrite = 1'b1; mem_wn = 5'd6; mem_alu = 32'd7;
    ins = itype(6'b000100, 5'd6, 5'd7, 16'd8);
    step(ins, 32'h200, 1'b1, 1'b0, 2'd1, 32'h220, mk(C_BR, ins, 32'h0, 32'd7));
    step(ins, 32'h200, 1'b1, 1'b0, 2'd0, 32'h0, mk(C_BR, ins, 32'h0, 32'd7));

    // producer in EX: stall, then forwarded from MEM
    ins = rtype(5'd3, 5'd3, 5'd6);
    step(ins, 32'h0, 1'b1, 1'b0, 2'd0, 32'h0, mk(C_R, ins, 32'h1234, 32'h1234));
    ins = itype(6'b000100, 5'd6, 5'd7, 16'd8);
    step(ins, 32'h200, 1'b1, 1'b1, 2'd0, 32'h0, BUBBLE);
    mem_regwrite = 1'b1; mem_wn = 5'd6; mem_alu = 32'd7;
    step(ins, 32'h200, 1'b1, 1'b0, 2'd1, 32'h220, mk(C_BR, ins, 32'h0, 32'd7));

    // load in MEM feeding a branch stalls
    mem_regwrite = 1'b1; mem_memread = 1'b1; mem_wn = 5'd7;
    step(ins, 32'h200, 1'b1, 1'b1, 2'd0, 32'h0, BUBBLE);

    // jump
    ins = {6'b000010, 26'h40};
    step(ins, 32'h1000_0004, 1'b1, 1'b0, 2'd2, 32'h1000_0100, mk(C_NOP, ins, 32'h0, 32'h0));

    // bne
    ins = itype(6'b000101, 5'd1, 5'd3, 16'd4);
`ifdef ID_BNE_EN
    step(ins, 32'h100, 1'b1, 1'b0, 2'd1, 32'h110, mk(C_BR, ins, 32'h0, 32'h1234));
`else
    step(ins, 32'h100, 1'b1, 1'b0, 2'd0, 32'h0, mk(C_NOP, ins, 32'h0, 32'h1234));
`endif

    // invalid slot: bubble, no redirect even for a jump word
    ins = {6'b000010, 26'h40};
    step(ins, 32'h1000_0004, 1'b0, 1'b0, 2'd0, 32'h0, BUBBLE);

    // reset in the middle of a load-use stall
    wb_regwrite = 1'b1; wb_wn = 5'd5; wb_wd = 32'h55;
    ins = itype(6'b100011, 5'd3, 5'd2, 16'h0);
    step(ins, 32'h0, 1'b1, 1'b0, 2'd0, 32'h0, mk(C_LW, ins, 32'h1234, 32'h0));
    if_instr = rtype(5'd2, 5'd2, 5'd4);
    #1;
    chk("pre_rst_stall", stall, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ctl", {ex_valid, ex_regwrite, ex_memread, ex_memtoreg, ex_alusrc}, 0);
    chk("mid_rst_rt", ex_rt, 5'd0);
    chk("mid_rst_stall", stall, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    ins = rtype(5'd5, 5'd3, 5'd8);
    step(ins, 32'h0, 1'b1, 1'b0, 2'd0, 32'h0, mk(C_R, ins, 32'h0, 32'h0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
